// File: rtl/cordic_log_arb_if.sv
// cordic_log_arb_if
// Bundles the requester, response and core-side signals of the
// cordic_log_arb sequencer.
//   requester side : req_valid, req_val, req_ready
//   response side  : rsp_valid, rsp_id, rsp_ln, rsp_err, rsp_ready, busy
//   core side      : core_val, core_rst, core_ce, core_ln, core_done
// Modports:
//   slave  - the arbiter
//   master - the surrounding system (requesters, consumer, core)
interface cordic_log_arb_if #(
  parameter int NREQ = 4,
  parameter int N    = 12,
  parameter int M    = 24
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_val;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [M-1:0]      rsp_ln;
  logic              rsp_err;
  logic              rsp_ready;
  logic              busy;
  logic [N-1:0]      core_val;
  logic              core_rst;
  logic              core_ce;
  logic [M-1:0]      core_ln;
  logic              core_done;

  modport slave (
    input  req_valid, req_val, rsp_ready, core_ln, core_done,
    output req_ready, rsp_valid, rsp_id, rsp_ln, rsp_err, busy,
           core_val, core_rst, core_ce
  );

  modport master (
    output req_valid, req_val, rsp_ready, core_ln, core_done,
    input  req_ready, rsp_valid, rsp_id, rsp_ln, rsp_err, busy,
           core_val, core_rst, core_ce
  );
endinterface

// File: rtl/cordic_log_arb.sv
// cordic_log_arb
// Round-robin arbiter that shares one cordic_log core among NREQ
// requesters. One operation in flight; the core is held in reset
// except while running, and every run is bounded by TIMEOUT cycles.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cordic_log_arb_if.slave (requests, response, core control)
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | wait for a request, grant round-robin from r_ptr
// CLR    | one-cycle synchronous reset pulse into the core
// RUN    | core enabled, wait for done or timeout
// RESP   | hold tagged result until consumer accepts
module cordic_log_arb #(
  parameter int NREQ    = 4,
  parameter int N       = 12,
  parameter int M       = 24,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cordic_log_arb_if.slave      bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [N-1:0]    r_val;
  logic [M-1:0]    r_ln;
  logic            r_err;
  logic [7:0]      r_cnt;
  logic            w_found;
  logic [IW-1:0]   w_gnt;
  logic [N-1:0]    w_opnd;
  logic            w_timeout;
  int              w_idx;

  // First pending requester at or after r_ptr, wrapping modulo NREQ
  // (NREQ need not be a power of two, so the wrap is explicit).
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_opnd  = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = IW'(w_idx);
        w_opnd  = bus.req_val[w_idx*N +: N];
      end
    end
  end

  assign w_timeout = (r_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.core_rst  = 1'b1;
    bus.core_ce   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        // rst_n gating keeps req_ready low while reset is held.
        if (rst_n && w_found) bus.req_ready = NREQ'(1) << w_gnt;
        if (w_found) w_next = (w_opnd == '0) ? S_RESP : S_CLR;
      end
      S_CLR: w_next = S_RUN;
      S_RUN: begin
        bus.core_rst = 1'b0;
        bus.core_ce  = 1'b1;
        // done takes priority over a coincident timeout
        if (bus.core_done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_val <= '0;
      r_ln  <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_val <= w_opnd;
            r_id  <= w_gnt;
            r_ln  <= '0;
            r_err <= (w_opnd == '0);
          end
        end
        S_CLR: r_cnt <= '0;
        S_RUN: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus.core_done) begin
            r_ln  <= bus.core_ln;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_ln  <= '0;
            r_err <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            if (r_id == IW'(NREQ - 1)) r_ptr <= '0;
            else                       r_ptr <= r_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_id   = r_id;
  assign bus.rsp_ln   = r_ln;
  assign bus.rsp_err  = r_err;
  assign bus.core_val = r_val;

endmodule

// File: tb/tb_cordic_log_arb.sv
// Directed testbench for cordic_log_arb with a behavioural core stub
// whose done delay and result are programmable.
module tb_cordic_log_arb;
  localparam int NREQ = 4;
  localparam int N    = 12;
  localparam int M    = 24;

  logic clk;
  logic rst_n;

  cordic_log_arb_if #(.NREQ(NREQ), .N(N), .M(M)) bus ();

  cordic_log_arb #(.NREQ(NREQ), .N(N), .M(M), .TIMEOUT(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stub: counts enabled cycles since its reset dropped; done
  // when the count reaches stub_d.
  logic [7:0]   stub_cnt;
  logic [7:0]   stub_d;
  logic [M-1:0] stub_val;
  logic         stub_never;

  always_ff @(posedge clk) begin
    if (bus.core_rst)                           stub_cnt <= 8'd0;
    else if (bus.core_ce && stub_cnt != 8'hFF)  stub_cnt <= stub_cnt + 8'd1;
  end

  assign bus.core_done = !bus.core_rst && !stub_never && (stub_cnt == stub_d);
  assign bus.core_ln   = stub_val;

  int n_cmp = 0;
  int n_err = 0;
  int k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_rsp(input int k0, output int kk);
    kk = k0;
    while (!bus.rsp_valid && kk < 100) begin
      cyc();
      kk++;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_val   = '0;
    bus.rsp_ready = 1'b0;
    stub_d        = 8'd23;
    stub_val      = 24'h010000;
    stub_never    = 1'b0;
    cyc();
    cyc();
    // reset values
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_core_rst",  bus.core_rst, 1);
    chk("rst_core_ce",   bus.core_ce, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_id",    bus.rsp_id, 0);
    chk("rst_rsp_ln",    bus.rsp_ln, 0);
    chk("rst_rsp_err",   bus.rsp_err, 0);
    chk("rst_core_val",  bus.core_val, 0);
    rst_n = 1'b1;
    cyc();

    // single request, d=23
    bus.req_valid = 4'b0001;
    bus.req_val[0*N +: N] = 12'h2B8;
    settle();
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_idle_core_rst", bus.core_rst, 1);
    cyc();
    bus.req_valid = '0;
    settle();
    chk("single_clr_core_rst", bus.core_rst, 1);
    chk("single_clr_core_ce",  bus.core_ce, 0);
    chk("single_clr_ready",    bus.req_ready, 0);
    chk("single_core_val",     bus.core_val, 12'h2B8);
    chk("single_busy",         bus.busy, 1);
    cyc();
    chk("single_run_core_rst", bus.core_rst, 0);
    chk("single_run_core_ce",  bus.core_ce, 1);
    wait_rsp(2, k);
    chk("single_latency", k, 26);
    chk("single_rsp_id",  bus.rsp_id, 0);
    chk("single_rsp_ln",  bus.rsp_ln, 24'h010000);
    chk("single_rsp_err", bus.rsp_err, 0);
    chk("single_rsp_core_rst", bus.core_rst, 1);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;

    // round-robin from a fresh pointer
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    stub_d   = 8'd3;
    stub_val = 24'h000123;
    bus.req_val = {12'h400, 12'h300, 12'h200, 12'h100};
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", bus.req_ready, 4'b0001 << (i % 4));
      cyc();
      wait_rsp(1, k);
      chk("rr_latency", k, 6);
      chk("rr_rsp_id",  bus.rsp_id, i % 4);
      chk("rr_rsp_ln",  bus.rsp_ln, 24'h000123);
      cyc();
      settle();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    cyc();

    // zero operand on requester 2 (pointer now at 1)
    bus.req_val[2*N +: N] = 12'h000;
    bus.req_valid = 4'b0100;
    settle();
    chk("zero_ready", bus.req_ready, 4'b0100);
    chk("zero_ce_t0", bus.core_ce, 0);
    cyc();
    bus.req_valid = '0;
    chk("zero_rsp_valid", bus.rsp_valid, 1);
    chk("zero_rsp_id",    bus.rsp_id, 2);
    chk("zero_rsp_err",   bus.rsp_err, 1);
    chk("zero_rsp_ln",    bus.rsp_ln, 0);
    chk("zero_ce_t1",     bus.core_ce, 0);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;

    // timeout on requester 3
    stub_never = 1'b1;
    bus.req_val[3*N +: N] = 12'h100;
    bus.req_valid = 4'b1000;
    settle();
    chk("to_ready", bus.req_ready, 4'b1000);
    cyc();
    bus.req_valid = '0;
    wait_rsp(1, k);
    chk("to_latency", k, 43);
    chk("to_rsp_id",  bus.rsp_id, 3);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_ln",  bus.rsp_ln, 0);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;

    // normal service after timeout
    stub_never = 1'b0;
    stub_d     = 8'd5;
    stub_val   = 24'h00ABCD;
    bus.req_val[0*N +: N] = 12'h080;
    bus.req_valid = 4'b0001;
    settle();
    chk("post_to_ready", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = '0;
    wait_rsp(1, k);
    chk("post_to_latency", k, 8);
    chk("post_to_rsp_ln",  bus.rsp_ln, 24'h00ABCD);
    chk("post_to_rsp_err", bus.rsp_err, 0);

    // backpressure: hold RESP for 10 cycles with a new request pending
    bus.req_val[1*N +: N] = 12'h123;
    bus.req_valid = 4'b0010;
    settle();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_id",    bus.rsp_id, 0);
      chk("bp_rsp_ln",    bus.rsp_ln, 24'h00ABCD);
      chk("bp_rsp_err",   bus.rsp_err, 0);
      chk("bp_req_ready", bus.req_ready, 0);
      cyc();
      settle();
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("bp_hs_req_ready", bus.req_ready, 0);
    cyc();
    bus.rsp_ready = 1'b0;
    settle();
    chk("bp_after_ready", bus.req_ready, 4'b0010);
    chk("bp_after_busy",  bus.busy, 0);
    cyc();
    cyc();
    settle();
    chk("rr_mid_run_ce",  bus.core_ce, 1);
    chk("rr_mid_run_val", bus.core_val, 12'h123);

    // asynchronous reset in RUN
    bus.req_val   = {12'h444, 12'h333, 12'h222, 12'h111};
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    settle();
    chk("arst_core_rst",  bus.core_rst, 1);
    chk("arst_core_ce",   bus.core_ce, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_busy",      bus.busy, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_core_val",  bus.core_val, 0);
    cyc();
    rst_n = 1'b1;
    settle();
    chk("arst_first_grant", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
